// File: rtl/sha256_multi.sv
// SHA-256/SHA-224 block-compression core behind a word-addressed register map.
// Each clock in ROUNDS performs UNROLL chained rounds.
module sha256_multi #(
    parameter int UNROLL     = 1,
    parameter int ENABLE_224 = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        we,
    input  logic [7:0]  address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        irq
);
    typedef enum logic [1:0] {IDLE = 2'd0, ROUNDS = 2'd1, DONE = 2'd2} state_t;
    typedef logic [7:0][31:0] vars_t;   // [0] = a ... [7] = h

    generate
        if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4)) begin : g_bad_unroll
            $error("sha256_multi: UNROLL must be 1, 2 or 4");
        end
    endgenerate

    localparam logic [5:0] LAST_T = 6'(64 - UNROLL);

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    function automatic vars_t sha_round(input vars_t v, input logic [31:0] kw);
        logic [31:0] t1;
        logic [31:0] t2;
        vars_t       r;
        t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
                  + ((v[4] & v[5]) ^ (~v[4] & v[6])) + kw;
        t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
           + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
        r[0] = t1 + t2;
        r[1] = v[0];
        r[2] = v[1];
        r[3] = v[2];
        r[4] = v[3] + t1;
        r[5] = v[4];
        r[6] = v[5];
        r[7] = v[6];
        return r;
    endfunction

    function automatic vars_t iv(input logic m);
        vars_t r;
        case (m)
            1'b1:    r = {32'hbefa4fa4, 32'h64f98fa7, 32'h68581511, 32'hffc00b31,
                          32'hf70e5939, 32'h3070dd17, 32'h367cd507, 32'hc1059ed8};
            default: r = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                          32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
        endcase
        return r;
    endfunction

    state_t      state_r, state_next_s;
    logic [5:0]  t_r;
    vars_t       h_r, wv_r;
    logic [31:0] win_r [16];
    logic [31:0] ext_s [16+UNROLL];
    vars_t       chain_s [UNROLL+1];
    logic        mode_r, irq_en_r, valid_r, err_r;
    logic        wr_s, ctrl_wr_s, blk_wr_s, stat_wr_s, ready_s, start_s, busy_err_s, mode_sel_s;

    assign wr_s       = cs & we;
    assign ctrl_wr_s  = wr_s && (address == 8'h08);
    assign blk_wr_s   = wr_s && (address[7:4] == 4'h1);
    assign stat_wr_s  = wr_s && (address == 8'h09);
    assign ready_s    = (state_r == IDLE);
    assign start_s    = ctrl_wr_s && ready_s && (write_data[0] || write_data[1]);
    assign busy_err_s = !ready_s && ((ctrl_wr_s && (write_data[0] || write_data[1])) || blk_wr_s);
    assign mode_sel_s = (ENABLE_224 != 0) ? write_data[2] : 1'b0;
    assign irq        = valid_r & irq_en_r;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) state_next_s = ROUNDS;
                else         state_next_s = IDLE;
            end
            ROUNDS: begin
                if (t_r == LAST_T) state_next_s = DONE;
                else               state_next_s = ROUNDS;
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Message schedule extension: words beyond the window chain on each other
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            ext_s[i] = win_r[i];
        end
        for (int u = 0; u < UNROLL; u++) begin
            ext_s[16+u] = ssig1(ext_s[14+u]) + ext_s[9+u] + ssig0(ext_s[1+u]) + ext_s[u];
        end
    end

    // Chained compression rounds t .. t+UNROLL-1
    always_comb begin
        chain_s[0] = wv_r;
        for (int u = 0; u < UNROLL; u++) begin
            chain_s[u+1] = sha_round(chain_s[u], K[t_r + 6'(u)] + ext_s[u]);
        end
    end

    // Datapath and control/status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            t_r      <= 6'd0;
            h_r      <= {8{32'd0}};
            wv_r     <= {8{32'd0}};
            mode_r   <= 1'b0;
            irq_en_r <= 1'b0;
            valid_r  <= 1'b0;
            err_r    <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                win_r[i] <= 32'd0;
            end
        end else begin
            if (ctrl_wr_s) irq_en_r <= write_data[3];
            // a new error outranks a simultaneous W1C clear
            if (busy_err_s)                        err_r <= 1'b1;
            else if (stat_wr_s && write_data[2])   err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_s && write_data[0]) begin
                        mode_r  <= mode_sel_s;
                        h_r     <= iv(mode_sel_s);
                        wv_r    <= iv(mode_sel_s);
                        valid_r <= 1'b0;
                        t_r     <= 6'd0;
                    end else if (start_s) begin
                        wv_r    <= h_r;
                        valid_r <= 1'b0;
                        t_r     <= 6'd0;
                    end
                    if (blk_wr_s) win_r[address[3:0]] <= write_data;
                end
                ROUNDS: begin
                    wv_r <= chain_s[UNROLL];
                    t_r  <= t_r + 6'(UNROLL);
                    for (int i = 0; i < 16; i++) begin
                        win_r[i] <= ext_s[i+UNROLL];
                    end
                end
                DONE: begin
                    for (int i = 0; i < 8; i++) begin
                        h_r[i] <= h_r[i] + wv_r[i];
                    end
                    valid_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Register read mux
    always_comb begin
        read_data = 32'd0;
        case (address)
            8'h08: read_data = {28'd0, irq_en_r, mode_r, 2'b00};
            8'h09: read_data = {29'd0, err_r, valid_r, ready_s};
            8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26:
                   read_data = h_r[address[2:0]];
            8'h27: begin
                if (mode_r) read_data = 32'd0;
                else        read_data = h_r[7];
            end
            default: read_data = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_sha256_multi.sv
// Bench for sha256_multi: three instances (UNROLL 1, 2, 4) driven in lockstep and
// checked against a FIPS 180-4 reference model and known digests.
module tb_sha256_multi;
    logic        clk = 1'b0;
    logic        reset, cs, we;
    logic [7:0]  address;
    logic [31:0] write_data;
    logic [31:0] rd [3];
    logic [2:0]  irq_v;

    int vectors = 0;
    int miscompares = 0;

    localparam int UNR [3] = '{1, 2, 4};

    always #5 clk = ~clk;

    sha256_multi #(.UNROLL(1)) u_dut1 (.clk(clk), .reset(reset), .cs(cs), .we(we), .address(address),
        .write_data(write_data), .read_data(rd[0]), .irq(irq_v[0]));
    sha256_multi #(.UNROLL(2)) u_dut2 (.clk(clk), .reset(reset), .cs(cs), .we(we), .address(address),
        .write_data(write_data), .read_data(rd[1]), .irq(irq_v[1]));
    sha256_multi #(.UNROLL(4)) u_dut4 (.clk(clk), .reset(reset), .cs(cs), .we(we), .address(address),
        .write_data(write_data), .read_data(rd[2]), .irq(irq_v[2]));

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef struct {
        logic [31:0]       ctrl;
        logic [0:15][31:0] blk;
        logic [0:7][31:0]  exp;
    } vec_t;

    vec_t tbl [10];

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [0:7][31:0] iv_of(input logic m);
        if (m) return {32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                       32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
        else   return {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                       32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    endfunction

    // Straight FIPS 180-4 compression of one block
    function automatic logic [0:7][31:0] compress(input logic [0:7][31:0] h, input logic [0:15][31:0] m);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2;
        logic [0:7][31:0] r;
        for (int i = 0; i < 16; i++) w[i] = m[i];
        for (int i = 16; i < 64; i++)
            w[i] = (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                 + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        for (int j = 0; j < 8; j++) v[j] = h[j];
        for (int i = 0; i < 64; i++) begin
            t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
                      + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[i] + w[i];
            t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int j = 0; j < 8; j++) r[j] = h[j] + v[j];
        return r;
    endfunction

    task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s (UNROLL=%0d): got %08h, expected %08h", name, UNR[inst], act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; we = 1'b1; address = a; write_data = d;
        @(negedge clk);
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [7:0] a, input logic [31:0] exp);
        @(negedge clk);
        address = a;
        #1;
        for (int i = 0; i < 3; i++) check(name, i, rd[i], exp);
    endtask

    task automatic write_block(input logic [0:15][31:0] b);
        for (int j = 0; j < 16; j++) wr(8'h10 + 8'(j), b[j]);
    endtask

    // Per-cycle ready/irq trace: ready returns 64/UNROLL+1 cycles after the start write
    task automatic run_wait(input logic irq_en_exp);
        logic done_exp;
        address = 8'h09;
        for (int k = 0; k < 66; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                done_exp = (k >= 64 / UNR[i] + 1);
                check("ready", i, {31'd0, rd[i][0]}, {31'd0, done_exp});
                check("irq", i, {31'd0, irq_v[i]}, {31'd0, done_exp & irq_en_exp});
            end
        end
    endtask

    task automatic check_digest(input string name, input logic [0:7][31:0] exp);
        for (int w = 0; w < 8; w++) rd_check(name, 8'h20 + 8'(w), exp[w]);
    endtask

    initial begin
        logic [0:15][31:0] abc, two1, two2;
        logic [0:7][31:0]  abc256, hm;
        logic              mm, init;

        abc  = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
        two1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
                32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        two2 = {{15{32'h00000000}}, 32'h000001c0};
        abc256 = {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                  32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};

        tbl[0].ctrl = 32'h1; tbl[0].blk = abc; tbl[0].exp = abc256;
        tbl[1].ctrl = 32'h5; tbl[1].blk = abc;
        tbl[1].exp  = {32'h23097d22, 32'h3405d822, 32'h8642a477, 32'hbda255b3,
                       32'h2aadbce4, 32'hbda0b3f7, 32'he36c9da7, 32'h00000000};
        tbl[2].ctrl = 32'h1; tbl[2].blk = two1; tbl[2].exp = compress(iv_of(1'b0), two1);
        tbl[3].ctrl = 32'h6; tbl[3].blk = two2;
        tbl[3].exp  = {32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
                       32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};
        mm = 1'b0;
        hm = tbl[3].exp;
        for (int v = 4; v < 10; v++) begin
            init = (v == 4) ? 1'b1 : 1'($urandom_range(0, 1));
            if (init) begin
                mm = 1'($urandom_range(0, 1));
                hm = iv_of(mm);
                tbl[v].ctrl = {29'd0, mm, 2'b01};
            end else begin
                tbl[v].ctrl = {29'd0, 1'($urandom_range(0, 1)), 2'b10};
            end
            for (int j = 0; j < 16; j++) tbl[v].blk[j] = $urandom;
            hm = compress(hm, tbl[v].blk);
            tbl[v].exp = hm;
            if (mm) tbl[v].exp[7] = 32'd0;
        end

        reset = 1'b1; cs = 1'b0; we = 1'b0; address = 8'h00; write_data = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rd_check("reset_status", 8'h09, 32'h1);
        rd_check("reset_ctrl", 8'h08, 32'h0);
        check_digest("reset_digest", {8{32'd0}});
        for (int i = 0; i < 3; i++) check("reset_irq", i, {31'd0, irq_v[i]}, 32'd0);

        for (int v = 0; v < 10; v++) begin
            write_block(tbl[v].blk);
            wr(8'h08, tbl[v].ctrl);
            run_wait(1'b0);
            check_digest($sformatf("digest_v%0d", v), tbl[v].exp);
            rd_check("status_done", 8'h09, 32'h3);
        end
        rd_check("ctrl_mode", 8'h08, {29'd0, mm, 2'b00});
        rd_check("unmapped_28", 8'h28, 32'h0);
        rd_check("block_wo", 8'h10, 32'h0);

        // Busy writes are dropped and flag err; DIGEST holds the freshly loaded IV
        write_block(abc);
        wr(8'h08, 32'h1);
        rd_check("busy_digest0", 8'h20, 32'h6a09e667);
        wr(8'h13, 32'hdeadbeef);
        wr(8'h08, 32'h2);
        repeat (70) @(negedge clk);
        check_digest("busy_digest", abc256);
        rd_check("busy_err", 8'h09, 32'h7);
        wr(8'h09, 32'h4);
        rd_check("err_clear", 8'h09, 32'h3);

        write_block(abc);
        wr(8'h08, 32'h9);
        run_wait(1'b1);
        rd_check("irq_status", 8'h09, 32'h3);
        rd_check("irq_ctrl", 8'h08, 32'h8);

        // Reset mid-hash, coinciding with a CTRL write
        write_block(abc);
        wr(8'h08, 32'h9);
        repeat (10) @(negedge clk);
        reset = 1'b1; cs = 1'b1; we = 1'b1; address = 8'h08; write_data = 32'h9;
        @(negedge clk);
        reset = 1'b0; cs = 1'b0; we = 1'b0;
        rd_check("abort_status", 8'h09, 32'h1);
        rd_check("abort_ctrl", 8'h08, 32'h0);
        check_digest("abort_digest", {8{32'd0}});
        for (int i = 0; i < 3; i++) check("abort_irq", i, {31'd0, irq_v[i]}, 32'd0);
        repeat (70) @(negedge clk);
        rd_check("abort_idle", 8'h09, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sha256_multi.md
SHA256_MULTI -- requirements
Module: sha256_multi

Interface
REQ-001 SHALL have parameter UNROLL, default 1, giving compression rounds per clock; legal values are 1, 2 and 4, and any other value SHALL fail elaboration.
REQ-002 SHALL have parameter ENABLE_224, default 1; when 1, SHA-224 mode is available, and when 0, the mode bit reads 0 and is ignored.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port cs, input, 1 bit: chip select.
REQ-006 SHALL have port we, input, 1 bit: write enable, qualified by cs.
REQ-007 SHALL have port address, input, 8 bits: word register address.
REQ-008 SHALL have port write_data, input, 32 bits: write payload.
REQ-009 SHALL have port read_data, output, 32 bits: combinational read of address, independent of cs.
REQ-010 SHALL have port irq, output, 1 bit: level interrupt equal to STATUS.valid AND CTRL.irq_en.

Function
REQ-011 SHALL implement this register map; unmapped addresses read 0 and writes to them are ignored:
- 0x08 CTRL: W bit0 init, W bit1 next, R/W bit2 mode (1 = SHA-224), R/W bit3 irq_en; bits 0/1 read 0.
- 0x09 STATUS: R bit0 ready, R bit1 valid, R/W1C bit2 err.
- 0x10-0x1F BLOCK0-15: W only.
- 0x20-0x27 DIGEST0-7: R only.
REQ-012 SHALL use FSM states IDLE, ROUNDS and DONE; ready = (state == IDLE).
REQ-013 In IDLE, a CTRL write with init=1 SHALL latch mode, load H0-H7 with the SHA-256 IVs (mode 0) or the SHA-224 IVs (mode 1: c1059ed8 367cd507 3070dd17 f70e5939 ffc00b31 68581511 64f98fa7 befa4fa4), copy them into the working variables a-h, clear valid, set t=0, and enter ROUNDS.
REQ-014 In IDLE, a CTRL write with next=1 and init=0 SHALL copy H0-H7 into a-h, clear valid and enter ROUNDS; it keeps the latched mode and ignores write_data bit2.
REQ-015 If init and next are both 1, init SHALL take priority.
REQ-016 Every CTRL write, in any state, SHALL update irq_en; mode updates only as part of init.
REQ-017 In ROUNDS, each cycle SHALL perform UNROLL chained FIPS 180-4 rounds t..t+UNROLL-1, all additions mod 2^32.
REQ-018 The 16-word schedule window SHALL shift by UNROLL per cycle, and new words SHALL be computed as sig1(W[t-2]) + W[t-7] + sig0(W[t-15]) + W[t-16].
REQ-019 t SHALL advance by UNROLL per cycle; the cycle that processes round 63 SHALL transition to DONE.
REQ-020 In DONE, each Hi SHALL be set to Hi + working variable i, valid set to 1, and the FSM SHALL return to IDLE.
REQ-021 Latency: ready SHALL be 0 from the cycle after the accepted init/next write until it returns to 1 exactly 64/UNROLL + 1 cycles after that write.
REQ-022 The BLOCK words SHALL be consumed by the schedule; after a block completes, their contents are unspecified and software rewrites all 16 words before the next next.
REQ-023 Any CTRL init/next or BLOCK write while ready=0 SHALL be ignored and SHALL set err; irq_en SHALL still update.
REQ-024 A STATUS write with bit2=1 SHALL clear err; if it coincides with a new error, set SHALL win.
REQ-025 In SHA-224 mode, DIGEST7 SHALL read 0; all H registers SHALL still update internally.
REQ-026 While busy, DIGEST reads SHALL return the previous H values, unchanged until DONE.

Reset
REQ-027 With reset high at a clock edge, the block SHALL enter IDLE and clear t, H0-H7, a-h, valid, err, mode and irq_en to 0, so irq=0 and STATUS reads 0x1.
REQ-028 Reset SHALL take priority over any concurrent write, and reset during ROUNDS or DONE SHALL abort without updating H; BLOCK contents after reset are unspecified.

Verification
REQ-029 Check SHA-256 "abc": write BLOCK0=61626380, BLOCK1-14=0, BLOCK15=00000018, then CTRL=0x1 -> ready=0 for 64/UNROLL+1 cycles, then DIGEST0-7 = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, STATUS=0x3.
REQ-030 Check SHA-224 "abc": same block, then CTRL=0x5 -> DIGEST0-6 = 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7, DIGEST7=0.
REQ-031 Check a two-block message: the 56-byte NIST vector "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" via init then next -> DIGEST0 = 248d6a61 and DIGEST7 = 19db06c1; run for UNROLL = 1, 2 and 4, with identical results and cycle counts of 65, 33 and 17.
REQ-032 Check busy-write protection: write BLOCK3 and CTRL=0x2 mid-hash -> digest unchanged vs REQ-029 and err=1; STATUS write 0x4 -> err=0.
REQ-033 Check irq and reset abort: CTRL=0x9 -> irq rises in the cycle valid sets; assert reset at round 20 -> STATUS=0x1, DIGEST0-7 = 0, irq=0.
